// File: rtl/mmu_pkg.sv
// Shared types and legal bounds for the N x N MMU operand feeder.
package mmu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        OUT,
        DONE
    } state_t;

    localparam int N_MIN = 2;
    localparam int N_MAX = 8;

endpackage

// File: rtl/mmu_skew_lane.sv
// One edge lane of the skewed operand wavefront: picks element k = t - LANE
// out of a snapshot row (A side) or column (B side), zero outside the window.
module mmu_skew_lane #(
    parameter int N    = 2,
    parameter int DW   = 8,
    parameter int TW   = 2,
    parameter int LANE = 0
) (
    input  logic [N*DW-1:0] vec,
    input  logic [TW-1:0]   t,
    output logic [DW-1:0]   sel
);

    // Select the element whose wavefront slot matches the current step.
    always_comb begin
        sel = '0;
        for (int k = 0; k < N; k++) begin
            if (t == TW'(k + LANE)) begin
                sel = vec[k*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/mmu_feeder_nxn.sv
// Operand scheduler and result serialiser for an N x N output-stationary
// systolic MMU.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | array held in clear, waiting for start
// CLEAR | one cycle of accumulator clear after the snapshot is taken
// FEED  | 2N-1 steps of skewed row/column streams into the array edges
// DRAIN | wait for the last wavefront to reach the far corner PE
// OUT   | present c_flat elements row-major, one per handshake
// DONE  | one-cycle completion pulse
module mmu_feeder_nxn
    import mmu_pkg::*;
#(
    parameter int N       = 2,
    parameter int DW      = 8,
    parameter int ACCW    = 16,
    parameter int ARR_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N*N*DW-1:0]     mat_a,
    input  logic [N*N*DW-1:0]     mat_b,
    input  logic [N*N*ACCW-1:0]   c_flat,
    output logic                  busy,
    output logic                  clear,
    output logic [N*DW-1:0]       a_data,
    output logic [N*DW-1:0]       b_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACCW-1:0]       out_data,
    output logic                  out_last,
    output logic                  done
);

    localparam int TW  = $clog2(2*N - 1);
    localparam int DRW = $clog2(N + ARR_LAT);
    localparam int IW  = $clog2(N*N);

    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("mmu_feeder_nxn: N out of supported range");
    end

    state_t              state_q, state_d;
    logic [N*N*DW-1:0]   snap_a_q, snap_b_q;
    logic [TW-1:0]       t_q;
    logic [DRW-1:0]      drain_q;
    logic [IW-1:0]       idx_q;
    logic [N*DW-1:0]     a_q, b_q, a_next, b_next;
    logic [N*DW-1:0]     col_b [N];
    logic [ACCW-1:0]     c_elem [N*N];
    logic                feed_end, drain_end, last_idx, hs;

    assign feed_end  = (t_q == TW'(2*N - 2));
    assign drain_end = (drain_q == '0);
    assign last_idx  = (idx_q == IW'(N*N - 1));
    assign hs        = (state_q == OUT) && out_ready;

    // Regroup the B snapshot into columns so each column lane sees B[k][j] at k.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            col_b[j] = '0;
            for (int k = 0; k < N; k++) begin
                col_b[j][k*DW +: DW] = snap_b_q[(k*N + j)*DW +: DW];
            end
        end
    end

    // Unpack the array results so the presented element is a plain index.
    always_comb begin
        for (int e = 0; e < N*N; e++) begin
            c_elem[e] = c_flat[e*ACCW +: ACCW];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        mmu_skew_lane #(.N(N), .DW(DW), .TW(TW), .LANE(i)) u_row (
            .vec (snap_a_q[i*N*DW +: N*DW]),
            .t   (t_q),
            .sel (a_next[i*DW +: DW])
        );
        mmu_skew_lane #(.N(N), .DW(DW), .TW(TW), .LANE(i)) u_col (
            .vec (col_b[i]),
            .t   (t_q),
            .sel (b_next[i*DW +: DW])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = FEED;
            FEED:    if (feed_end) state_d = DRAIN;
            DRAIN:   if (drain_end) state_d = OUT;
            OUT:     if (hs && last_idx) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Snapshot, step counters and registered edge streams.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_a_q <= '0;
            snap_b_q <= '0;
            t_q      <= '0;
            drain_q  <= '0;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                snap_a_q <= mat_a;
                snap_b_q <= mat_b;
            end
            t_q <= (state_q == FEED && !feed_end) ? t_q + 1'b1 : '0;
            if (state_q == FEED) begin
                drain_q <= DRW'(N - 2 + ARR_LAT);
            end else if (state_q == DRAIN && !drain_end) begin
                drain_q <= drain_q - 1'b1;
            end
            if (state_q != OUT) begin
                idx_q <= '0;
            end else if (hs && !last_idx) begin
                idx_q <= idx_q + 1'b1;
            end
            a_q <= (state_q == FEED) ? a_next : '0;
            b_q <= (state_q == FEED) ? b_next : '0;
        end
    end

    // Results are read live from the array, which holds them while clear is low.
    assign out_valid = (state_q == OUT);
    assign out_data  = (state_q == OUT) ? c_elem[idx_q] : '0;
    assign out_last  = (state_q == OUT) && last_idx;
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign clear     = (state_q == IDLE) || (state_q == CLEAR);
    assign done      = (state_q == DONE);
    assign a_data    = a_q;
    assign b_data    = b_q;

endmodule

// File: tb/tb_mmu_feeder_nxn.sv
// Directed bench for mmu_feeder_nxn at N=2 and N=4, each driving a
// behavioural output-stationary systolic array model.
module tb_mmu_feeder_nxn;

    logic clk, rst_n;

    logic         start2, out_ready2, busy2, clear2, out_valid2, out_last2, done2;
    logic [31:0]  mat_a2, mat_b2;
    logic [63:0]  c_flat2;
    logic [15:0]  a_data2, b_data2, out_data2;

    logic         start4, out_ready4, busy4, clear4, out_valid4, out_last4, done4;
    logic [127:0] mat_a4, mat_b4;
    logic [255:0] c_flat4;
    logic [31:0]  a_data4, b_data4;
    logic [15:0]  out_data4;

    int tests_run    = 0;
    int tests_failed = 0;

    mmu_feeder_nxn #(.N(2), .DW(8), .ACCW(16), .ARR_LAT(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mat_a(mat_a2), .mat_b(mat_b2),
        .c_flat(c_flat2), .busy(busy2), .clear(clear2), .a_data(a_data2),
        .b_data(b_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_last(out_last2), .done(done2)
    );

    mmu_feeder_nxn #(.N(4), .DW(8), .ACCW(16), .ARR_LAT(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mat_a(mat_a4), .mat_b(mat_b4),
        .c_flat(c_flat4), .busy(busy4), .clear(clear4), .a_data(a_data4),
        .b_data(b_data4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_data(out_data4), .out_last(out_last4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 2x2 array: operands ripple right/down, PEs accumulate.
    logic [7:0]  ain2 [2][2], bin2 [2][2], pa2 [2][2], pb2 [2][2];
    logic [15:0] acc2 [2][2];
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ain2[i][0] = a_data2[i*8 +: 8];
            bin2[0][i] = b_data2[i*8 +: 8];
            for (int j = 1; j < 2; j++) begin
                ain2[i][j] = pa2[i][j-1];
                bin2[j][i] = pb2[j-1][i];
            end
        end
    end
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                pa2[i][j]  <= ain2[i][j];
                pb2[i][j]  <= bin2[i][j];
                acc2[i][j] <= clear2 ? 16'd0 : acc2[i][j] + 16'(ain2[i][j]) * 16'(bin2[i][j]);
            end
        end
    end
    always_comb begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                c_flat2[(i*2+j)*16 +: 16] = acc2[i][j];
    end

    // Behavioural 4x4 array, same structure.
    logic [7:0]  ain4 [4][4], bin4 [4][4], pa4 [4][4], pb4 [4][4];
    logic [15:0] acc4 [4][4];
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ain4[i][0] = a_data4[i*8 +: 8];
            bin4[0][i] = b_data4[i*8 +: 8];
            for (int j = 1; j < 4; j++) begin
                ain4[i][j] = pa4[i][j-1];
                bin4[j][i] = pb4[j-1][i];
            end
        end
    end
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pa4[i][j]  <= ain4[i][j];
                pb4[i][j]  <= bin4[i][j];
                acc4[i][j] <= clear4 ? 16'd0 : acc4[i][j] + 16'(ain4[i][j]) * 16'(bin4[i][j]);
            end
        end
    end
    always_comb begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                c_flat4[(i*4+j)*16 +: 16] = acc4[i][j];
    end

    // A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C=[[19,22],[43,50]]
    localparam logic [31:0] A2 = 32'h04030201;
    localparam logic [31:0] B2 = 32'h08070605;

    // Drive a one-cycle start; returns at the negedge of cycle 1 (CLEAR).
    task automatic pulse_start2(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mat_a2 = a;
        mat_b2 = b;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy2, clear2, out_valid2, out_last2, done2} !== 5'b01000) begin
            tests_failed++;
            $display("FAIL reset_ctrl2 got %b want 01000", {busy2, clear2, out_valid2, out_last2, done2});
        end
        tests_run++;
        if ({a_data2, b_data2, out_data2} !== 48'h0) begin
            tests_failed++;
            $display("FAIL reset_data2 got %h want 0", {a_data2, b_data2, out_data2});
        end
        tests_run++;
        if ({busy4, clear4, out_valid4, out_last4, done4, a_data4, b_data4, out_data4} !== {5'b01000, 80'h0}) begin
            tests_failed++;
            $display("FAIL reset_4 got %b/%h want 01000/0", {busy4, clear4, out_valid4, out_last4, done4},
                     {a_data4, b_data4, out_data4});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream();
        logic [15:0] exp_a [3] = '{16'h0001, 16'h0302, 16'h0400};
        logic [15:0] exp_b [3] = '{16'h0005, 16'h0607, 16'h0800};
        logic [15:0] exp_c [4] = '{16'd19, 16'd22, 16'd43, 16'd50};
        out_ready2 = 1'b1;
        pulse_start2(A2, B2);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc == 1) begin
                tests_run++;
                if ({busy2, clear2, a_data2, b_data2} !== {2'b11, 32'h0}) begin
                    tests_failed++;
                    $display("FAIL clear_cycle got %b/%h want 11/0", {busy2, clear2}, {a_data2, b_data2});
                end
            end
            if (cyc == 2 || cyc == 6) begin
                tests_run++;
                if ({clear2, out_valid2, a_data2, b_data2} !== 34'h0) begin
                    tests_failed++;
                    $display("FAIL idle_stream cyc=%0d got %b%b/%h want 00/0", cyc, clear2, out_valid2,
                             {a_data2, b_data2});
                end
            end
            if (cyc >= 3 && cyc <= 5) begin
                tests_run++;
                if ({a_data2, b_data2} !== {exp_a[cyc-3], exp_b[cyc-3]}) begin
                    tests_failed++;
                    $display("FAIL stream t=%0d got a=%h b=%h want a=%h b=%h", cyc-3, a_data2, b_data2,
                             exp_a[cyc-3], exp_b[cyc-3]);
                end
            end
            if (cyc >= 7 && cyc <= 10) begin
                tests_run++;
                if ({out_valid2, out_data2, out_last2} !== {1'b1, exp_c[cyc-7], cyc == 10}) begin
                    tests_failed++;
                    $display("FAIL result idx=%0d got v=%b d=%0d l=%b want v=1 d=%0d l=%b", cyc-7,
                             out_valid2, out_data2, out_last2, exp_c[cyc-7], cyc == 10);
                end
            end
            if (cyc == 11) begin
                tests_run++;
                if ({done2, busy2, out_valid2} !== 3'b100) begin
                    tests_failed++;
                    $display("FAIL done_cycle got %b want 100", {done2, busy2, out_valid2});
                end
            end
            if (cyc == 12) begin
                tests_run++;
                if ({done2, clear2} !== 2'b01) begin
                    tests_failed++;
                    $display("FAIL after_done got %b want 01", {done2, clear2});
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_c [4] = '{16'd19, 16'd22, 16'd43, 16'd50};
        logic        pat [4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
        int hs = 0, p = 0, ndone = 0;
        pulse_start2(A2, B2);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (done2) ndone++;
            if (out_valid2 && hs < 4) begin
                tests_run++;
                if ({out_data2, out_last2} !== {exp_c[hs], hs == 3}) begin
                    tests_failed++;
                    $display("FAIL bp_elem hs=%0d got d=%0d l=%b want d=%0d l=%b", hs, out_data2,
                             out_last2, exp_c[hs], hs == 3);
                end
                out_ready2 = pat[p % 4];
                p++;
                if (out_ready2) hs++;
            end else if (out_valid2) begin
                tests_run++;
                tests_failed++;
                $display("FAIL bp_extra got valid after %0d handshakes want none", hs);
            end
            @(negedge clk);
        end
        out_ready2 = 1'b1;
        tests_run++;
        if (hs !== 4 || ndone !== 1) begin
            tests_failed++;
            $display("FAIL bp_count got hs=%0d done=%0d want hs=4 done=1", hs, ndone);
        end
    endtask

    task automatic test_start_ignored();
        int rises = 0, ndone = 0, busy_cycles = 0;
        logic busy_prev = 1'b0;
        out_ready2 = 1'b1;
        pulse_start2(A2, B2);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (busy2 && !busy_prev) rises++;
            if (busy2) busy_cycles++;
            busy_prev = busy2;
            if (done2) ndone++;
            start2 = (cyc == 3) || done2;
            @(negedge clk);
        end
        start2 = 1'b0;
        tests_run++;
        if (rises !== 1 || ndone !== 1) begin
            tests_failed++;
            $display("FAIL start_ignored got rises=%0d done=%0d want 1/1", rises, ndone);
        end
        tests_run++;
        if (busy_cycles !== 10) begin
            tests_failed++;
            $display("FAIL busy_window got %0d want 10", busy_cycles);
        end
        tests_run++;
        if (busy2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_restart got busy=%b want 0", busy2);
        end
    endtask

    task automatic test_snapshot();
        logic [15:0] exp_c [4] = '{16'd19, 16'd22, 16'd43, 16'd50};
        out_ready2 = 1'b1;
        pulse_start2(A2, B2);
        mat_a2 = 32'hFFFFFFFF;
        mat_b2 = 32'hFFFFFFFF;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            if (cyc >= 7 && cyc <= 10) begin
                tests_run++;
                if ({out_valid2, out_data2} !== {1'b1, exp_c[cyc-7]}) begin
                    tests_failed++;
                    $display("FAIL snapshot idx=%0d got v=%b d=%0d want v=1 d=%0d", cyc-7, out_valid2,
                             out_data2, exp_c[cyc-7]);
                end
            end
            @(negedge clk);
        end
        mat_a2 = A2;
        mat_b2 = B2;
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_c [4] = '{16'd19, 16'd22, 16'd43, 16'd50};
        int ndone = 0;
        out_ready2 = 1'b1;
        pulse_start2(A2, B2);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy2, clear2, out_valid2, out_last2, done2, a_data2, b_data2, out_data2} !== {5'b01000, 48'h0}) begin
            tests_failed++;
            $display("FAIL reset_mid got %b/%h want 01000/0", {busy2, clear2, out_valid2, out_last2, done2},
                     {a_data2, b_data2, out_data2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (done2 || busy2) ndone++;
            @(negedge clk);
        end
        tests_run++;
        if (ndone !== 0) begin
            tests_failed++;
            $display("FAIL reset_abort got %0d busy/done cycles want 0", ndone);
        end
        pulse_start2(A2, B2);
        for (int cyc = 1; cyc <= 11; cyc++) begin
            if (cyc >= 7 && cyc <= 10) begin
                tests_run++;
                if ({out_valid2, out_data2, out_last2} !== {1'b1, exp_c[cyc-7], cyc == 10}) begin
                    tests_failed++;
                    $display("FAIL rerun idx=%0d got v=%b d=%0d want v=1 d=%0d", cyc-7, out_valid2,
                             out_data2, exp_c[cyc-7]);
                end
            end
            if (cyc == 11) begin
                tests_run++;
                if (done2 !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rerun_done got %b want 1", done2);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_n4();
        int first = -1, n = 0, ndone = 0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                mat_a4[(i*4+k)*8 +: 8] = (i == k) ? 8'd1 : 8'd0;
                mat_b4[(i*4+k)*8 +: 8] = 8'(i*4 + k);
            end
        end
        out_ready4 = 1'b1;
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (out_valid4 && first < 0) first = cyc;
            if (out_valid4) begin
                tests_run++;
                if ({out_data4, out_last4} !== {16'(n), n == 15}) begin
                    tests_failed++;
                    $display("FAIL n4_elem idx=%0d got d=%0d l=%b want d=%0d l=%b", n, out_data4,
                             out_last4, n, n == 15);
                end
                n++;
            end
            if (done4) ndone++;
            @(negedge clk);
        end
        tests_run++;
        if (first !== 13) begin
            tests_failed++;
            $display("FAIL n4_latency got %0d want 13", first);
        end
        tests_run++;
        if (n !== 16 || ndone !== 1) begin
            tests_failed++;
            $display("FAIL n4_count got n=%0d done=%0d want 16/1", n, ndone);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start2     = 1'b0;
        start4     = 1'b0;
        out_ready2 = 1'b1;
        out_ready4 = 1'b1;
        mat_a2     = '0;
        mat_b2     = '0;
        mat_a4     = '0;
        mat_b4     = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_start_ignored();
        test_snapshot();
        test_reset_mid();
        test_n4();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
